// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: note codes, ROM entry layout, FSM states
// and the note-to-tone-divider mapping.
package melody_pkg;

    typedef enum logic [2:0] {SIL, DO, RE, MI, FA, SO, LA, SI_} note_t;

    // Storage width of the duration field; players narrow it to their own DUR_W.
    localparam int DUR_MAX_W = 8;

    typedef struct packed {
        note_t                  note;
        logic [DUR_MAX_W-1:0]   dur;
    } entry_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [31:0] note_divisor(input note_t n);
        case (n)
            DO:      return 32'd191571;
            RE:      return 32'd170648;
            MI:      return 32'd151515;
            FA:      return 32'd143266;
            SO:      return 32'd127551;
            LA:      return 32'd113636;
            SI_:     return 32'd101239;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song table: combinational lookup of {note, duration} by index, zero latency.
// Indices past the song length read as one beat of silence; durations saturate to DUR_W.
module melody_rom
    import melody_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int SONG_LEN = 59,
    parameter int DUR_W    = 3
) (
    input  logic [ADDR_W-1:0] idx,
    output note_t             note,
    output logic [DUR_W-1:0]  dur
);

    localparam int DUR_SAT = (1 << DUR_W) - 1;

    entry_t entry;

    always_comb begin
        entry = '{note: SIL, dur: DUR_MAX_W'(1)};
        if (int'(idx) < SONG_LEN) begin
            case (int'(idx))
                0:       entry = '{note: SO,  dur: DUR_MAX_W'(2)};
                1:       entry = '{note: LA,  dur: DUR_MAX_W'(2)};
                2:       entry = '{note: DO,  dur: DUR_MAX_W'(4)};
                3:       entry = '{note: MI,  dur: DUR_MAX_W'(2)};
                4:       entry = '{note: RE,  dur: DUR_MAX_W'(2)};
                5:       entry = '{note: DO,  dur: DUR_MAX_W'(4)};
                6:       entry = '{note: FA,  dur: DUR_MAX_W'(2)};
                7:       entry = '{note: MI,  dur: DUR_MAX_W'(2)};
                8:       entry = '{note: RE,  dur: DUR_MAX_W'(4)};
                9:       entry = '{note: SO,  dur: DUR_MAX_W'(2)};
                10:      entry = '{note: LA,  dur: DUR_MAX_W'(2)};
                11:      entry = '{note: SI_, dur: DUR_MAX_W'(4)};
                default: entry = '{note: SIL, dur: DUR_MAX_W'(1)};
            endcase
        end
    end

    // A zero duration would never expire, so it plays as a single beat.
    always_comb begin
        if (entry.dur == '0)
            dur = DUR_W'(1);
        else if (int'(entry.dur) > DUR_SAT)
            dur = '1;
        else
            dur = entry.dur[DUR_W-1:0];
    end

    assign note = entry.note;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: walks the song ROM on beat ticks and drives the tone divider.
// All outputs registered, 1 clk after the causing input; pause holds position silently.
module melody_player
    import melody_pkg::*;
#(
    parameter int DIV_W    = 22,
    parameter int ADDR_W   = 6,
    parameter int SONG_LEN = 59,
    parameter int DUR_W    = 3,
    parameter int GAP_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_mode,
    output logic [DIV_W-1:0]  note_div,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done
);

    logic [2:0]        state, ret_state, nxt_state, nxt_ret;
    logic [ADDR_W-1:0] nxt_idx;
    logic [DUR_W-1:0]  dur_cnt, nxt_dur, rom_dur;
    note_t             rom_note;
    logic              reload, dec, adv, last;

    // The ROM looks at the next index so reloads and the divider track the new entry.
    melody_rom #(
        .ADDR_W   (ADDR_W),
        .SONG_LEN (SONG_LEN),
        .DUR_W    (DUR_W)
    ) u_rom (
        .idx  (nxt_idx),
        .note (rom_note),
        .dur  (rom_dur)
    );

    assign last = (idx == ADDR_W'(SONG_LEN - 1));

    always_comb begin
        nxt_state = state;
        nxt_ret   = ret_state;
        nxt_idx   = idx;
        reload    = 1'b0;
        dec       = 1'b0;
        adv       = 1'b0;
        if (stop) begin
            nxt_state = S_IDLE;
            nxt_idx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nxt_state = S_PLAY;
                        nxt_idx   = '0;
                        reload    = 1'b1;
                    end
                end
                S_PLAY, S_GAP: begin
                    // A tick arriving with pause is dropped, not banked.
                    if (pause) begin
                        nxt_state = S_PAUSE;
                        nxt_ret   = state;
                    end else if (beat_tick) begin
                        if (state == S_GAP)
                            adv = 1'b1;
                        else if (dur_cnt > DUR_W'(1))
                            dec = 1'b1;
                        else if (GAP_EN != 0)
                            nxt_state = S_GAP;
                        else
                            adv = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause)
                        nxt_state = ret_state;
                end
                default: nxt_state = S_IDLE;
            endcase
            if (adv) begin
                if (!last) begin
                    nxt_idx   = idx + ADDR_W'(1);
                    nxt_state = S_PLAY;
                    reload    = 1'b1;
                end else if (loop_mode) begin
                    nxt_idx   = '0;
                    nxt_state = S_PLAY;
                    reload    = 1'b1;
                end else begin
                    nxt_state = S_DONE;
                end
            end
        end
    end

    always_comb begin
        nxt_dur = dur_cnt;
        if (reload)
            nxt_dur = rom_dur;
        else if (dec)
            nxt_dur = dur_cnt - DUR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            idx       <= '0;
            dur_cnt   <= '0;
            note_div  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            ret_state <= nxt_ret;
            idx       <= nxt_idx;
            dur_cnt   <= nxt_dur;
            note_div  <= (nxt_state == S_PLAY) ? DIV_W'(note_divisor(rom_note)) : '0;
            busy      <= (nxt_state == S_PLAY) || (nxt_state == S_GAP) || (nxt_state == S_PAUSE);
            done      <= (nxt_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: a legato and a gapped instance share stimulus; expected
// per-clock outputs are queued at each start and popped on every falling edge.
module tb_melody_player;

    localparam int BT   = 8;
    localparam int D_SO = 127551;
    localparam int D_LA = 113636;
    localparam int D_DO = 191571;

    logic        clk = 1'b0;
    logic        rst, beat_tick, start, stop, pause, loop_mode;
    logic [21:0] nd0, nd1;
    logic [5:0]  ix0, ix1;
    logic        busy0, busy1, done0, done1;

    melody_player #(.DIV_W(22), .ADDR_W(6), .SONG_LEN(3), .DUR_W(3), .GAP_EN(0)) dut0 (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .start(start), .stop(stop),
        .pause(pause), .loop_mode(loop_mode),
        .note_div(nd0), .idx(ix0), .busy(busy0), .done(done0)
    );

    melody_player #(.DIV_W(22), .ADDR_W(6), .SONG_LEN(3), .DUR_W(3), .GAP_EN(1)) dut1 (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .start(start), .stop(stop),
        .pause(pause), .loop_mode(loop_mode),
        .note_div(nd1), .idx(ix1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div;
        int ix;
        int busy;
        int done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ix < 0 marks the index as don't-care (after a natural end of song).
    task automatic push(input int which, input int div, input int ix, input int b,
                        input int d, input int n);
        exp_t e;
        e = '{div, ix, b, d};
        repeat (n) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
    endtask

    task automatic push_song(input int which, input int gap);
        push(which, D_SO, 0, 1, 0, 2*BT);
        if (gap != 0) push(which, 0, 0, 1, 0, BT);
        push(which, D_LA, 1, 1, 0, 2*BT);
        if (gap != 0) push(which, 0, 1, 1, 0, BT);
        push(which, D_DO, 2, 1, 0, 4*BT);
        if (gap != 0) push(which, 0, 2, 1, 0, BT);
        push(which, 0, -1, 0, 1, 1);
        push(which, 0, -1, 0, 0, 10);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        beat_tick = (cyc % BT == 0);
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Start lands on a beat edge, so every note spans whole beats of 8 clks.
    task automatic kick();
        while (!beat_tick) step();
        start = 1'b1;
        step();
    endtask

    task automatic quiesce();
        stop = 1'b1;
        step();
        run(3);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("div0", 32'(nd0), e.div);
                if (e.ix >= 0) check("idx0", 32'(ix0), e.ix);
                check("busy0", 32'(busy0), e.busy);
                check("done0", 32'(done0), e.done);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("div1", 32'(nd1), e.div);
                if (e.ix >= 0) check("idx1", 32'(ix1), e.ix);
                check("busy1", 32'(busy1), e.busy);
                check("done1", 32'(done1), e.done);
            end
        end
    end

    initial begin
        rst = 1'b0; beat_tick = 1'b0; start = 1'b0; stop = 1'b0;
        pause = 1'b0; loop_mode = 1'b0;
        #2 rst = 1'b1;
        run(3);
        check("rst_div", 32'(nd0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_idx", 32'(ix0), 0);
        check("rst_done", 32'(done0), 0);

        // Idle after reset: silent, not busy, no done pulse.
        rst = 1'b0;
        push(0, 0, 0, 0, 0, 100);
        push(1, 0, 0, 0, 0, 100);
        run(100);

        // One-shot, legato.
        quiesce();
        kick();
        push_song(0, 0);
        run(100);

        // Looping: two full passes, then the wrap back to entry 0, then stop.
        quiesce();
        loop_mode = 1'b1;
        kick();
        repeat (2) begin
            push(0, D_SO, 0, 1, 0, 2*BT);
            push(0, D_LA, 1, 1, 0, 2*BT);
            push(0, D_DO, 2, 1, 0, 4*BT);
        end
        push(0, D_SO, 0, 1, 0, 4);
        push(0, 0, 0, 0, 0, 10);
        run(131);
        stop = 1'b1;
        run(12);
        loop_mode = 1'b0;

        // Five-beat pause after the first beat of SO; one beat of SO remains.
        quiesce();
        kick();
        push(0, D_SO, 0, 1, 0, 9);
        push(0, 0, 0, 1, 0, 5*BT);
        push(0, D_SO, 0, 1, 0, 7);
        push(0, D_LA, 1, 1, 0, 2*BT);
        push(0, D_DO, 2, 1, 0, 4*BT);
        push(0, 0, -1, 0, 1, 1);
        push(0, 0, -1, 0, 0, 10);
        run(8);
        pause = 1'b1;
        run(5*BT);
        pause = 1'b0;
        run(70);

        // Pause rising on a beat edge swallows that tick: SO keeps both beats.
        quiesce();
        kick();
        push(0, D_SO, 0, 1, 0, 8);
        push(0, 0, 0, 1, 0, 1);
        push(0, D_SO, 0, 1, 0, 15);
        push(0, D_LA, 1, 1, 0, 2*BT);
        push(0, D_DO, 2, 1, 0, 4*BT);
        push(0, 0, -1, 0, 1, 1);
        push(0, 0, -1, 0, 0, 10);
        run(7);
        pause = 1'b1;
        run(1);
        pause = 1'b0;
        run(90);

        // Gapped instance: a silent beat after each note, 11 beats in total.
        quiesce();
        kick();
        push_song(0, 0);
        push_song(1, 1);
        run(110);

        // Stop together with a beat tick in the middle of LA.
        quiesce();
        kick();
        push(0, D_SO, 0, 1, 0, 2*BT);
        push(0, D_LA, 1, 1, 0, BT);
        push(0, 0, 0, 0, 0, 10);
        push(1, D_SO, 0, 1, 0, 2*BT);
        push(1, 0, 0, 1, 0, BT);
        push(1, 0, 0, 0, 0, 10);
        run(3*BT - 1);
        stop = 1'b1;
        run(15);

        // Asynchronous reset in the middle of SO silences before the next edge.
        quiesce();
        kick();
        push(0, D_SO, 0, 1, 0, 10);
        run(9);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_div", 32'(nd0), 0);
        check("arst_busy", 32'(busy0), 0);
        check("arst_idx", 32'(ix0), 0);
        step();
        step();
        rst = 1'b0;
        run(4);
        check("post_rst_div", 32'(nd0), 0);

        check("q0_drain", q0.size(), 0);
        check("q1_drain", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
